// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the SoC reset sequencer: controller states, reset-cause codes
// and a counter-width helper.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_POR        = 2'd0,
        CAUSE_READY_LOSS = 2'd1,
        CAUSE_BUTTON     = 2'd2
    } cause_e;

    // Width of a counter that must hold values 0..maxVal without wrapping.
    function automatic int ctrWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchroniser with synchronous active-high reset; bring async
// ready/button levels into the clk domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= d_i;
            stage2_q <= stage1_q;
        end
    end

    assign q_o = stage2_q;

endmodule

// File: rtl/reset_sequencer.sv
// SoC reset controller: waits for all ready inputs to be stable, releases reset
// domains in ascending staggered order, and aborts on ready loss or button press.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int CLK_FREQ        = 20_250_000,
    parameter int NUM_READY       = 1,
    parameter int NUM_OUTPUTS     = 2,
    parameter int HOLD_CYCLES     = 1024,
    parameter int STAGGER_CYCLES  = 16,
    parameter int DEBOUNCE_CYCLES = 202_500,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_READY-1:0]   ready_in,
    input  logic                   btn,
    output logic [NUM_OUTPUTS-1:0] rst_out,
    output logic                   all_released,
    output logic [1:0]             cause
);

    localparam int CntMax = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES - 1 : STAGGER_CYCLES - 1;
    localparam int CW     = ctrWidth(CntMax);
    localparam int DW     = ctrWidth(DEBOUNCE_CYCLES - 1);

    if (CLK_FREQ < 1 || NUM_READY < 1 || NUM_OUTPUTS < 1 || HOLD_CYCLES < 1 ||
        STAGGER_CYCLES < 1 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
        $error("reset_sequencer: parameter out of range");
    end

    logic [NUM_READY-1:0]   readySync;
    logic                   btnSync;
    logic                   readyOk;
    logic                   btnActive;
    logic                   press;
    logic [DW-1:0]          dbCnt_q;
    logic                   armed_q;
    state_e                 state_q;
    cause_e                 cause_q;
    logic [CW-1:0]          cnt_q;
    logic [NUM_OUTPUTS-1:0] rstOut_q;
    logic                   allRel_q;
    logic [NUM_OUTPUTS-1:0] relNext;

    sync_2ff #(.WIDTH(NUM_READY)) uReadySync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (ready_in),
        .q_o   (readySync)
    );

    sync_2ff #(.WIDTH(1)) uBtnSync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (btn),
        .q_o   (btnSync)
    );

    assign readyOk   = &readySync;
    assign btnActive = (BTN_ACTIVE_LOW != 0) ? ~btnSync : btnSync;
    assign press     = armed_q && (dbCnt_q == DW'(DEBOUNCE_CYCLES - 1));
    assign relNext   = rstOut_q << 1;

    // Debounce starts disarmed so the all-zero sync flops after reset cannot fake a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbCnt_q <= '0;
            armed_q <= 1'b0;
        end else if (!btnActive) begin
            dbCnt_q <= '0;
            armed_q <= 1'b1;
        end else begin
            if (dbCnt_q != DW'(DEBOUNCE_CYCLES - 1)) begin
                dbCnt_q <= dbCnt_q + DW'(1);
            end
            if (press) begin
                armed_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ASSERT;
            cause_q  <= CAUSE_POR;
            cnt_q    <= '0;
            rstOut_q <= '1;
            allRel_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    rstOut_q <= '1;
                    allRel_q <= 1'b0;
                    cnt_q    <= '0;
                    if (readyOk) begin
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!readyOk || press) begin
                        state_q <= ST_ASSERT;
                        cnt_q   <= '0;
                        if (readyOk) begin
                            cause_q <= CAUSE_BUTTON;
                        end
                    end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                        cnt_q    <= '0;
                        rstOut_q <= relNext;
                        if (relNext == '0) begin
                            state_q  <= ST_RUN;
                            allRel_q <= 1'b1;
                        end else begin
                            state_q <= ST_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_RELEASE, ST_RUN: begin
                    // Ready loss has priority over a press on the same edge.
                    if (!readyOk || press) begin
                        state_q  <= ST_ASSERT;
                        cnt_q    <= '0;
                        rstOut_q <= '1;
                        allRel_q <= 1'b0;
                        cause_q  <= readyOk ? CAUSE_BUTTON : CAUSE_READY_LOSS;
                    end else if (state_q == ST_RELEASE) begin
                        if (cnt_q == CW'(STAGGER_CYCLES - 1)) begin
                            cnt_q    <= '0;
                            rstOut_q <= relNext;
                            if (relNext == '0) begin
                                state_q  <= ST_RUN;
                                allRel_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_ASSERT;
                end
            endcase
        end
    end

    assign rst_out      = rstOut_q;
    assign all_released = allRel_q;
    assign cause        = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a timeline-based reference model predicts the
// outputs after every edge, and a monitor compares them half a cycle later.
module tb_reset_sequencer;

    localparam int NR  = 2;
    localparam int NO  = 3;
    localparam int H   = 8;
    localparam int S   = 4;
    localparam int DEB = 5;

    typedef struct {
        logic [NO-1:0] rstOut;
        logic          allRel;
        logic [1:0]    cause;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] ready_in = '0;
    logic          btn = 1'b1;
    logic [NO-1:0] rst_out;
    logic          all_released;
    logic [1:0]    cause;

    exp_t expQ[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: the release schedule is a timeline anchored at the edge where
    // the stable ready level was first seen; bit i clears at seqStart + H + S*i.
    int            edgeNum = 0;
    int            seqStart = -1;
    int            causeM = 0;
    logic [NR-1:0] rs1 = '0, rs2 = '0;
    logic          bs1 = 1'b0, bs2 = 1'b0;
    int            dbRun = 0;
    bit            dbArmed = 1'b0;

    reset_sequencer #(
        .NUM_READY       (NR),
        .NUM_OUTPUTS     (NO),
        .HOLD_CYCLES     (H),
        .STAGGER_CYCLES  (S),
        .DEBOUNCE_CYCLES (DEB),
        .BTN_ACTIVE_LOW  (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ready_in     (ready_in),
        .btn          (btn),
        .rst_out      (rst_out),
        .all_released (all_released),
        .cause        (cause)
    );

    always #5 clk = ~clk;

    task automatic modelStep(input logic [NR-1:0] r, input logic b, input logic rs);
        bit   okSeen, actSeen, pressSeen, inHold;
        exp_t e;
        if (rs) begin
            edgeNum  = 0;
            seqStart = -1;
            causeM   = 0;
            rs1 = '0; rs2 = '0; bs1 = 1'b0; bs2 = 1'b0;
            dbRun    = 0;
            dbArmed  = 1'b0;
        end else begin
            edgeNum++;
            okSeen    = &rs2;
            actSeen   = !bs2;
            pressSeen = dbArmed && (dbRun == DEB - 1);
            if (seqStart < 0) begin
                if (okSeen) seqStart = edgeNum;
            end else begin
                inHold = (edgeNum - 1) < (seqStart + H);
                if (!okSeen) begin
                    if (!inHold) causeM = 1;
                    seqStart = -1;
                end else if (pressSeen) begin
                    causeM   = 2;
                    seqStart = -1;
                end
            end
            if (!actSeen) begin
                dbRun   = 0;
                dbArmed = 1'b1;
            end else begin
                if (dbRun < DEB - 1) dbRun++;
                if (pressSeen) dbArmed = 1'b0;
            end
            rs2 = rs1; rs1 = r;
            bs2 = bs1; bs1 = b;
        end
        for (int i = 0; i < NO; i++) begin
            e.rstOut[i] = !(seqStart >= 0 && edgeNum >= seqStart + H + S * i);
        end
        e.allRel = (seqStart >= 0 && edgeNum >= seqStart + H + S * (NO - 1));
        e.cause  = 2'(causeM);
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [NR-1:0] r, input logic b, input logic rs, input int n);
        for (int k = 0; k < n; k++) begin
            ready_in = r;
            btn      = b;
            rst      = rs;
            modelStep(r, b, rs);
            @(negedge clk);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        total++;
        if (rst_out !== e.rstOut) begin
            bad++;
            $display("[TB] FAIL rst_out @%0t: got %b expected %b", $time, rst_out, e.rstOut);
        end
        total++;
        if (all_released !== e.allRel) begin
            bad++;
            $display("[TB] FAIL all_released @%0t: got %b expected %b", $time, all_released, e.allRel);
        end
        total++;
        if (cause !== e.cause) begin
            bad++;
            $display("[TB] FAIL cause @%0t: got %0d expected %0d", $time, cause, e.cause);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
        end
    end

    initial begin
        logic [NR-1:0] r;
        logic          b;
        $display("[TB] reset_sequencer scoreboard bench start");

        applyStimulus(2'b00, 1'b1, 1'b1, 2);
        applyStimulus(2'b11, 1'b1, 1'b0, 30);

        applyStimulus(2'b11, 1'b1, 1'b1, 1);
        applyStimulus(2'b11, 1'b1, 1'b0, 6);
        applyStimulus(2'b01, 1'b1, 1'b0, 1);
        applyStimulus(2'b11, 1'b1, 1'b0, 30);

        applyStimulus(2'b10, 1'b1, 1'b0, 5);
        applyStimulus(2'b11, 1'b1, 1'b0, 30);

        applyStimulus(2'b11, 1'b0, 1'b0, 3);
        applyStimulus(2'b11, 1'b1, 1'b0, 20);
        applyStimulus(2'b11, 1'b0, 1'b0, 12);
        applyStimulus(2'b11, 1'b1, 1'b0, 30);
        applyStimulus(2'b11, 1'b0, 1'b0, 100);
        applyStimulus(2'b11, 1'b1, 1'b0, 30);

        // Press qualification and ready loss both reach the FSM at edge 17 (rst_out=100).
        applyStimulus(2'b11, 1'b1, 1'b1, 1);
        applyStimulus(2'b11, 1'b1, 1'b0, 10);
        applyStimulus(2'b11, 1'b0, 1'b0, 4);
        applyStimulus(2'b10, 1'b0, 1'b0, 1);
        applyStimulus(2'b11, 1'b0, 1'b0, 2);
        applyStimulus(2'b11, 1'b1, 1'b0, 30);

        applyStimulus(2'b11, 1'b1, 1'b1, 1);
        applyStimulus(2'b11, 1'b1, 1'b0, 13);
        applyStimulus(2'b11, 1'b1, 1'b1, 1);
        applyStimulus(2'b11, 1'b1, 1'b0, 30);

        for (int k = 0; k < 200; k++) begin
            r = ($urandom_range(0, 7) == 0) ? NR'($urandom_range(0, 3)) : 2'b11;
            b = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 39) == 0) begin
                applyStimulus(r, b, 1'b1, 1);
            end else begin
                applyStimulus(r, b, 1'b0, $urandom_range(1, 25));
            end
        end

        applyStimulus(2'b11, 1'b1, 1'b0, 2);
        @(negedge clk);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
